// File: rtl/ram16x8_burst_ctrl.sv
// Burst sequencer in front of a 16x8 single-port RAM: streams write beats in,
// issues reads with one-cycle RAM latency and buffers read data in a small FIFO.
module ram16x8_burst_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [3:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       busy,
    output logic       ram_ce,
    output logic       ram_rd_en,
    output logic       ram_wr_en,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    input  logic       ram_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state, state_nxt;

    logic [3:0]    addr_q, last_addr;
    logic [4:0]    remaining;
    logic          inflight, wr_beat, issue, push, pop;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [CW:0]   occupancy;

    // Reads in flight count against FIFO space, so a full FIFO never overflows.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign busy      = (state != IDLE);
    assign push      = inflight & ram_valid;
    assign rd_valid  = (count != '0);
    assign pop       = rd_valid & rd_ready;
    assign rptr_nxt  = pop ? rptr + AW'(1) : rptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (!push && pop)
            count_nxt = count - CW'(1);
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        wr_beat   = 1'b0;
        issue     = 1'b0;
        ram_ce    = 1'b0;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;
        ram_addr  = last_addr;
        ram_wdata = 8'd0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                wr_ready = 1'b1;
                wr_beat  = wr_valid;
                if (wr_beat) begin
                    ram_ce    = 1'b1;
                    ram_wr_en = 1'b1;
                    ram_addr  = addr_q;
                    ram_wdata = wr_data;
                    if (remaining == 5'd1)
                        state_nxt = IDLE;
                end
            end
            READ: begin
                issue     = (remaining != 5'd0) && (occupancy < DEPTH_W);
                // Holding rd_en while a read is in flight keeps the RAM output visible.
                ram_ce    = issue | inflight;
                ram_rd_en = issue | inflight;
                if (issue)
                    ram_addr = addr_q;
                // remaining==0 here means this is the drain cycle of the last issue.
                if (remaining == 5'd0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= 4'd0;
            last_addr <= 4'd0;
            remaining <= 5'd0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && cmd_valid) begin
                addr_q    <= cmd_addr;
                remaining <= {1'b0, cmd_len} + 5'd1;
            end else if (wr_beat || issue) begin
                addr_q    <= addr_q + 4'd1;
                last_addr <= addr_q;
                remaining <= remaining - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr] <= ram_rdata;
    end

    // rd_data is the registered head; a push into the head slot bypasses the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= 8'd0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            rptr  <= rptr_nxt;
            count <= count_nxt;
            if (count_nxt == '0)
                rd_data <= 8'd0;
            else if (push && wptr == rptr_nxt)
                rd_data <= ram_rdata;
            else
                rd_data <= fifo_mem[rptr_nxt];
        end
    end
endmodule

// File: tb/tb_ram16x8_burst_ctrl.sv
// Bench for ram16x8_burst_ctrl: RAM model, directed burst table, corner sequences
// and random bursts checked against a memory/queue reference.
module tb_ram16x8_burst_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'd0, cmd_len = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, rd_ready = 1'b0, busy;
    logic       ram_ce, ram_rd_en, ram_wr_en, ram_valid;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram16x8_burst_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
        .ram_ce(ram_ce), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_valid(ram_valid)
    );

    // RAM: data one cycle after a read, visible only while ce&rd_en stay high.
    logic [7:0] ram_mem [16];
    logic [7:0] ram_dq;
    logic       ram_vq;
    always @(posedge clk) begin
        if (ram_ce && ram_wr_en) ram_mem[ram_addr] <= ram_wdata;
        if (ram_ce && ram_rd_en) begin
            ram_dq <= ram_mem[ram_addr];
            ram_vq <= 1'b1;
        end else
            ram_vq <= 1'b0;
    end
    assign ram_rdata = ram_dq;
    assign ram_valid = ram_vq & ram_ce & ram_rd_en;

    typedef struct {
        logic            wr;
        logic [3:0]      addr;
        logic [3:0]      len;
        logic [3:0][7:0] d;   // write data, or expected read data
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];
    int         n_vec = 0, n_err = 0, rd_en_cnt = 0, rr_mode = 1, pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive rd_ready, sample just after the falling edge, pass a rising edge.
    task automatic tick();
        logic [7:0] e;
        case (rr_mode)
            0: rd_ready = 1'b0;
            1: rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (ram_rd_en) rd_en_cnt++;
        if (rd_valid && rd_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got %0h expected none", rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", {24'd0, rd_data}, {24'd0, e});
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
        check({tag, "_wr_ready"}, {31'd0, wr_ready}, 0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 0);
        check({tag, "_rd_data"}, {24'd0, rd_data}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_ram_en"}, {29'd0, ram_ce, ram_rd_en, ram_wr_en}, 0);
        check({tag, "_ram_addr"}, {28'd0, ram_addr}, 0);
        check({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 0);
    endtask

    task automatic cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len);
        logic hs;
        int   guard = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        do begin
            hs = cmd_ready;
            tick();
            guard++;
        end while (!hs && guard < 400);
        if (!hs) check("cmd_handshake_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    // gap: 0 none, 1 alternate idle cycle before each later beat, 2 random idles
    task automatic do_write(input logic [3:0] addr, input logic [3:0] len,
                            input logic [3:0][7:0] d, input int gap);
        logic [7:0] b;
        logic [3:0] a;
        cmd(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                wr_valid = 1'b0;
                #1;
                check("gap_ram_ce", {31'd0, ram_ce}, 0);
                tick();
            end
            b = (i < 4) ? d[i] : 8'($urandom);
            a = addr + 4'(i);
            wr_valid = 1'b1;
            wr_data  = b;
            #1;
            check("wr_ready", {31'd0, wr_ready}, 1);
            check("wr_beat_en", {30'd0, ram_ce, ram_wr_en}, 3);
            check("wr_beat_addr", {28'd0, ram_addr}, {28'd0, a});
            check("wr_beat_data", {24'd0, ram_wdata}, {24'd0, b});
            ref_mem[a] = b;
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("busy_after_write", {31'd0, busy}, 0);
    endtask

    // Full read with latency and drain checks; FIFO must be empty beforehand.
    task automatic do_read_full(input logic [3:0] addr, input logic [3:0] len,
                                input logic [3:0][7:0] d, input logic use_tbl);
        int guard = 0;
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back((use_tbl && i < 4) ? d[i] : ref_mem[addr + 4'(i)]);
        rr_mode = 1;
        rd_en_cnt = 0;
        cmd(1'b0, addr, len);
        check("lat_e0", {31'd0, rd_valid}, 0);
        tick();
        check("lat_e1", {31'd0, rd_valid}, 0);
        tick();
        check("lat_e2", {31'd0, rd_valid}, 1);
        while ((exp_q.size() != 0 || busy) && guard < 100) begin
            tick();
            guard++;
        end
        check("read_drained", exp_q.size(), 0);
        check("rd_en_cycles", rd_en_cnt, int'(len) + 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][7:0] rd4;
        int guard;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        ram_dq = 8'd0;
        ram_vq = 1'b0;
        tbl[0] = '{1'b1, 4'd2,  4'd3, {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
        tbl[1] = '{1'b0, 4'd2,  4'd3, {8'hA3, 8'hA2, 8'hA1, 8'hA0}};
        tbl[2] = '{1'b1, 4'd14, 4'd3, {8'h44, 8'h33, 8'h22, 8'h11}};
        tbl[3] = '{1'b0, 4'd0,  4'd1, {8'h00, 8'h00, 8'h44, 8'h33}};
        tbl[4] = '{1'b0, 4'd15, 4'd0, {8'h00, 8'h00, 8'h00, 8'h22}};

        @(negedge clk);
        #1;
        check_reset_outs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outs("idle");

        for (int v = 0; v < 5; v++) begin
            if (tbl[v].wr) do_write(tbl[v].addr, tbl[v].len, tbl[v].d, 0);
            else           do_read_full(tbl[v].addr, tbl[v].len, tbl[v].d, 1'b1);
        end

        // Gapped write then read back
        do_write(4'd8, 4'd3, {8'h5D, 8'h5C, 8'h5B, 8'h5A}, 1);
        do_read_full(4'd8, 4'd3, {8'h5D, 8'h5C, 8'h5B, 8'h5A}, 1'b1);

        // Backpressure: FIFO fills to 4, issue stalls, then all 16 drain in order
        for (int i = 0; i < 16; i++) exp_q.push_back(ref_mem[4'(i)]);
        rr_mode = 0;
        rd_en_cnt = 0;
        cmd(1'b0, 4'd0, 4'd15);
        for (int i = 0; i < 20; i++) tick();
        check("bp_rd_en_cycles", rd_en_cnt, 5);
        check("bp_stalled", {30'd0, ram_rd_en, busy}, 1);
        check("bp_rd_valid", {31'd0, rd_valid}, 1);
        check("bp_no_pops", exp_q.size(), 16);
        rr_mode = 1;
        pops = 0;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 200) begin
            tick();
            guard++;
        end
        check("bp_pops", pops, 16);
        check("bp_empty", {31'd0, rd_valid}, 0);

        // Reset in the middle of a read burst
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[4'd3 + 4'(i)]);
        rr_mode = 1;
        cmd(1'b0, 4'd3, 4'd7);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("post_rst_rd_valid", {31'd0, rd_valid}, 0);
        rd4 = '0;
        do_read_full(4'd3, 4'd7, rd4, 1'b0);

        // Random bursts against the reference memory/queue
        rr_mode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [3:0] a, l;
            a = 4'($urandom);
            l = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd4 = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
                do_write(a, l, rd4, 2);
            end else begin
                for (int i = 0; i <= int'(l); i++) exp_q.push_back(ref_mem[a + 4'(i)]);
                cmd(1'b0, a, l);
            end
        end
        rr_mode = 1;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 300) begin
            tick();
            guard++;
        end
        check("rand_drained", exp_q.size(), 0);
        check("rand_empty", {31'd0, rd_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
